// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select lines {A,B} of a shared 4-to-1 mux.
// Grants are registered, one-hot, and each tenure is capped at MAX_HOLD cycles.
module mux_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] REQ,
   input  logic [3:0] LAST,
   output logic [3:0] GNT,
   output logic       A,
   output logic       B,
   output logic       VALID
);

   localparam int            HW        = $clog2(MAX_HOLD) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state;
   logic [1:0]    ptr;
   logic [1:0]    g;
   logic [HW-1:0] hold_cnt;

   // Returns {found, index}: first requester at or after start, wrapping mod 4.
   function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   logic       rel_now;
   logic [1:0] scan_start;
   logic [2:0] pick;
   logic       do_grant;

   // On release the scan starts just past the grantee, so it can only win if nobody else asks.
   always_comb begin
      rel_now    = !REQ[g] || LAST[g] || (hold_cnt == HOLD_LAST);
      scan_start = (state == GRANT) ? g + 2'd1 : ptr;
      pick       = rr_pick(REQ, scan_start);
      do_grant   = pick[2] && ((state == IDLE) || rel_now);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         GNT      <= 4'b0000;
         A        <= 1'b0;
         B        <= 1'b0;
         VALID    <= 1'b0;
         ptr      <= 2'd0;
         g        <= 2'd0;
         hold_cnt <= '0;
      end else begin
         if (state == GRANT && rel_now) ptr <= g + 2'd1;

         if (do_grant) begin
            state    <= GRANT;
            g        <= pick[1:0];
            GNT      <= 4'b0001 << pick[1:0];
            A        <= pick[1];
            B        <= pick[0];
            VALID    <= 1'b1;
            hold_cnt <= '0;
         end else if (state == GRANT && !rel_now) begin
            hold_cnt <= hold_cnt + HW'(1);
         end else if (state == GRANT) begin
            // Nobody left to serve: drop the grant but keep the selects where they were.
            state <= IDLE;
            GNT   <= 4'b0000;
            VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a behavioural model queues the expected
// outputs for every driven cycle, which are popped and compared after the edge.
module tb_mux_rr_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] REQ;
   logic [3:0] LAST;
   logic [3:0] GNT;
   logic       A;
   logic       B;
   logic       VALID;
   logic [3:0] mux_i;
   logic       y;

   mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset_n(reset_n), .REQ(REQ), .LAST(LAST),
      .GNT(GNT), .A(A), .B(B), .VALID(VALID)
   );

   always #5 clk = ~clk;

   // External mux driven by the arbiter's selects.
   assign y = mux_i[{A, B}];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int         m_busy;
   int         m_ptr;
   int         m_g;
   int         m_hold;
   logic [3:0] m_gnt;
   logic       m_a;
   logic       m_b;
   logic       m_vld;

   logic [6:0] exp_q[$];

   task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic rn);
      int  first;
      int  winner;
      bit  released;
      if (!rn) begin
         m_busy = 0; m_ptr = 0; m_g = 0; m_hold = 0;
         m_gnt = 4'b0000; m_a = 1'b0; m_b = 1'b0; m_vld = 1'b0;
         return;
      end
      winner = -1;
      if (m_busy == 0) begin
         first = m_ptr;
      end else begin
         released = (r[m_g] == 1'b0) || (l[m_g] == 1'b1) || (m_hold == MAX_HOLD - 1);
         if (!released) begin
            m_hold++;
            return;
         end
         m_ptr = (m_g + 1) % 4;
         first = m_ptr;
      end
      for (int i = 0; i < 4 && winner < 0; i++)
         if (r[(first + i) % 4]) winner = (first + i) % 4;
      if (winner >= 0) begin
         m_busy = 1; m_g = winner; m_hold = 0;
         m_gnt = 4'b0000; m_gnt[winner] = 1'b1;
         m_a = (winner >= 2); m_b = (winner % 2 == 1); m_vld = 1'b1;
      end else begin
         m_busy = 0; m_gnt = 4'b0000; m_vld = 1'b0;
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rn);
      logic [6:0] e;
      REQ = r; LAST = l; reset_n = rn;
      model_step(r, l, rn);
      exp_q.push_back({m_gnt, m_a, m_b, m_vld});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("sb_out", {25'd0, GNT, A, B, VALID}, {25'd0, e});
   endtask

   initial begin
      reset_n = 1'b0; REQ = 4'b0000; LAST = 4'b0000; mux_i = 4'b0000;
      @(negedge clk);

      // T1: reset holds everything at zero even with all requests up
      step(4'b1111, 4'b0000, 1'b0);
      step(4'b1111, 4'b0000, 1'b0);
      chk("t1_gnt", {28'd0, GNT}, 32'h0);
      chk("t1_sel", {30'd0, A, B}, 32'h0);
      chk("t1_vld", {31'd0, VALID}, 32'h0);

      // T3: full load rotation 0,1,2,3,0 with 4-cycle tenures
      for (int c = 0; c < 17; c++) begin
         step(4'b1111, 4'b0000, 1'b1);
         chk("t3_gnt", {28'd0, GNT}, 32'h1 << ((c / MAX_HOLD) % 4));
         chk("t3_vld", {31'd0, VALID}, 32'h1);
      end

      // T2: idle, then single request from requester 2; Y follows I[2]
      step(4'b0000, 4'b0000, 1'b0);
      step(4'b0100, 4'b0000, 1'b1);
      chk("t2_gnt", {28'd0, GNT}, 32'h4);
      chk("t2_sel", {30'd0, A, B}, 32'h2);
      mux_i = 4'b0100; #1;
      chk("t2_y_hi", {31'd0, y}, 32'h1);
      mux_i = 4'b1011; #1;
      chk("t2_y_lo", {31'd0, y}, 32'h0);

      // T4: grantee 2 ends early with LAST on its 2nd cycle, requester 3 next
      step(4'b0100, 4'b0000, 1'b1);
      step(4'b1101, 4'b0100, 1'b1);
      chk("t4_gnt", {28'd0, GNT}, 32'h8);
      chk("t4_sel", {30'd0, A, B}, 32'h3);

      // T5: grantee 1 drops request -> idle with selects held, then ptr=2 picks 0
      step(4'b0000, 4'b0000, 1'b0);
      step(4'b0010, 4'b0000, 1'b1);
      chk("t5_gnt1", {28'd0, GNT}, 32'h2);
      step(4'b0000, 4'b0000, 1'b1);
      chk("t5_idle", {28'd0, GNT, VALID}, 32'h0);
      chk("t5_hold", {30'd0, A, B}, 32'h1);
      step(4'b0011, 4'b0000, 1'b1);
      chk("t5_gnt0", {28'd0, GNT}, 32'h1);

      // T6: reset mid-grant of requester 3 at hold_cnt 2
      step(4'b0000, 4'b0000, 1'b0);
      step(4'b1000, 4'b0000, 1'b1);
      step(4'b1000, 4'b0000, 1'b1);
      step(4'b1000, 4'b0000, 1'b1);
      chk("t6_pre", {28'd0, GNT}, 32'h8);
      step(4'b1000, 4'b0000, 1'b0);
      chk("t6_rst", {25'd0, GNT, A, B, VALID}, 32'h0);
      step(4'b1001, 4'b0000, 1'b1);
      chk("t6_gnt", {28'd0, GNT}, 32'h1);

      // Sole requester is re-granted after its tenure expires
      for (int c = 0; c < 2 * MAX_HOLD; c++) begin
         step(4'b0001, 4'b0000, 1'b1);
         chk("sole_gnt", {28'd0, GNT, VALID}, 32'h3);
      end

      // Random traffic with occasional reset; also invariants each cycle
      for (int c = 0; c < 400; c++) begin
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
              ($urandom_range(0, 49) != 0));
         chk("inv_vld", {31'd0, VALID}, {31'd0, |GNT});
         if (VALID) chk("inv_sel", {28'd0, GNT}, 32'h1 << {A, B});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
